mips_multicycle_ctrl: RTL and testbench

- Multicycle sequencer for the MIPS core. It replaces single-cycle control with a per-instruction state machine that drives a shared ALU/memory datapath.
- Supports add, sub, and, or, nor, slt, lw, sw, addi, beq and j.
- Sits between the instruction register (opCode input) and the datapath muxes, register file, PC and unified memory.
- Stalls on a memory-ready handshake, supports run/stop stepping and flags illegal opcodes.

---
 rtl/mips_multicycle_ctrl_if.sv | 33 +++
 rtl/mips_multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - datapath control bus between the MIPS sequencer and its datapath
interface mips_multicycle_ctrl_if;
  logic       run;
  logic [5:0] opCode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;

  // Sequencer side: consumes IR/memory status, drives datapath controls
  modport master (
    input  run, opCode, mem_ready,
    output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp
  );

  // Datapath side
  modport slave (
    output run, opCode, mem_ready,
    input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control sequencer with memory stall, run/stop and illegal-op trap
module mips_multicycle_ctrl #(
  parameter bit TRAP_ON_ILLEGAL = 1'b0,
  parameter int CNT_W           = 32
) (
  input  logic                 clk,
  input  logic                 resetN,
  mips_multicycle_ctrl_if.master bus,
  output logic                 instr_done,
  output logic                 illegal_op,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired_cnt,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13,
    S_HALT    = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Moore part of the control word; in_fetch/in_memwr mark the states whose
  // strobes are additionally qualified by mem_ready in the current cycle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       done;
    logic       illegal;
    logic       halt;
    logic       in_fetch;
    logic       in_memwr;
  } ctrl_t;

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           after_retire;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.in_fetch  = 1'b1;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        c.in_memwr  = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.done          = 1'b1;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.done      = 1'b1;
      end
      S_ILLEGAL: c.illegal = 1'b1;
      S_HALT:    c.halt    = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Next state, next registered control word and next counter value
  always_comb begin
    after_retire = bus.run ? S_FETCH : S_IDLE;
    state_d      = state_q;
    case (state_q)
      S_IDLE:   state_d = bus.run ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opCode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_d = (bus.opCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = after_retire;
      S_MEMWR:   state_d = bus.mem_ready ? after_retire : S_MEMWR;
      S_EXEC:    state_d = S_ALUWB;
      S_ALUWB:   state_d = after_retire;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = after_retire;
      S_BRANCH:  state_d = after_retire;
      S_JUMP:    state_d = after_retire;
      S_ILLEGAL: state_d = TRAP_ON_ILLEGAL ? S_HALT : after_retire;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
    ctrl_d = decode(state_d);
    cnt_d  = instr_done ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end

  // State, control word and retire counter; async reset clears all outputs at once
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PCWrite     = ctrl_q.pc_write | (ctrl_q.in_fetch & bus.mem_ready);
  assign bus.IRWrite     = ctrl_q.in_fetch & bus.mem_ready;
  assign bus.PCWriteCond = ctrl_q.pc_write_cond;
  assign bus.PCSource    = ctrl_q.pc_source;
  assign bus.IorD        = ctrl_q.iord;
  assign bus.MemRead     = ctrl_q.mem_read;
  assign bus.MemWrite    = ctrl_q.mem_write;
  assign bus.MemtoReg    = ctrl_q.mem_to_reg;
  assign bus.RegDst      = ctrl_q.reg_dst;
  assign bus.RegWrite    = ctrl_q.reg_write;
  assign bus.ALUSrcA     = ctrl_q.alu_src_a;
  assign bus.ALUSrcB     = ctrl_q.alu_src_b;
  assign bus.ALUOp       = ctrl_q.alu_op;
  assign instr_done      = ctrl_q.done | (ctrl_q.in_memwr & bus.mem_ready);
  assign illegal_op      = ctrl_q.illegal;
  assign halted          = ctrl_q.halt;
  assign retired_cnt     = cnt_q;
  assign state           = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for the multicycle MIPS sequencer
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rstn0, rstn1;
  logic        run, mem_ready;
  logic [5:0]  op;
  logic        sel;

  logic        done0, ill0, hlt0, done1, ill1, hlt1;
  logic [31:0] cnt0, cnt1;
  logic [3:0]  st0, st1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] st;
    logic       mr;
    logic       rn;
    logic [5:0] op;
  } step_t;

  step_t sb[$];
  int    step_no = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus0 ();
  mips_multicycle_ctrl_if bus1 ();

  assign bus0.run       = run;
  assign bus0.opCode    = op;
  assign bus0.mem_ready = mem_ready;
  assign bus1.run       = run;
  assign bus1.opCode    = op;
  assign bus1.mem_ready = mem_ready;

  mips_multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0), .CNT_W(32)) dut0 (
    .clk(clk), .resetN(rstn0), .bus(bus0),
    .instr_done(done0), .illegal_op(ill0), .halted(hlt0),
    .retired_cnt(cnt0), .state(st0)
  );

  mips_multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1), .CNT_W(32)) dut1 (
    .clk(clk), .resetN(rstn1), .bus(bus1),
    .instr_done(done1), .illegal_op(ill1), .halted(hlt1),
    .retired_cnt(cnt1), .state(st1)
  );

  // Expected outputs straight from the state table
  function automatic logic [22:0] exp_vec(input logic [3:0] s, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rd, rw, asa, done, ill, hlt;
    logic [1:0] pcs, asb, aop;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rd, rw, asa, done, ill, hlt} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (s)
      4'd1:  begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
      4'd2:  asb = 2'b11;
      4'd3:  begin asa = 1; asb = 2'b10; end
      4'd4:  begin mrd = 1; iord = 1; end
      4'd5:  begin m2r = 1; rw = 1; done = 1; end
      4'd6:  begin mwr = 1; iord = 1; done = mr; end
      4'd7:  begin asa = 1; aop = 2'b10; end
      4'd8:  begin rd = 1; rw = 1; done = 1; end
      4'd9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: begin rw = 1; done = 1; end
      4'd12: begin pcw = 1; pcs = 2'b10; done = 1; end
      4'd13: ill = 1;
      4'd14: hlt = 1;
      default: ;
    endcase
    return {s, pcw, pcwc, pcs, iord, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, done, ill, hlt};
  endfunction

  function automatic logic [22:0] obs_vec();
    if (sel)
      return {st1, bus1.PCWrite, bus1.PCWriteCond, bus1.PCSource, bus1.IorD, bus1.MemRead,
              bus1.MemWrite, bus1.IRWrite, bus1.MemtoReg, bus1.RegDst, bus1.RegWrite,
              bus1.ALUSrcA, bus1.ALUSrcB, bus1.ALUOp, done1, ill1, hlt1};
    return {st0, bus0.PCWrite, bus0.PCWriteCond, bus0.PCSource, bus0.IorD, bus0.MemRead,
            bus0.MemWrite, bus0.IRWrite, bus0.MemtoReg, bus0.RegDst, bus0.RegWrite,
            bus0.ALUSrcA, bus0.ALUSrcB, bus0.ALUOp, done0, ill0, hlt0};
  endfunction

  task automatic chk_vec(input string tag, input logic [22:0] expv);
    logic [22:0] o;
    o = obs_vec();
    checks++;
    assert (o === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, expv);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] expc);
    logic [31:0] o;
    o = sel ? cnt1 : cnt0;
    checks++;
    assert (o === expc) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, expc);
    end
  endtask

  task automatic push(input logic [3:0] s, input logic mr, input logic rn, input logic [5:0] o);
    step_t e;
    e.st = s; e.mr = mr; e.rn = rn; e.op = o;
    sb.push_back(e);
  endtask

  // Pop one expected step per clock: drive its inputs, compare, advance
  task automatic drain();
    step_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.mr;
      run       = e.rn;
      op        = e.op;
      #1;
      chk_vec($sformatf("step%0d_state%0d", step_no, e.st), exp_vec(e.st, e.mr));
      step_no++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    sel = 1'b0; rstn0 = 1'b0; rstn1 = 1'b0;
    run = 1'b0; mem_ready = 1'b0; op = 6'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Both cores held in reset: everything zero
    chk_vec("reset0_outputs", '0);
    chk_cnt("reset0_cnt", 32'd0);
    sel = 1'b1;
    chk_vec("reset1_outputs", '0);
    chk_cnt("reset1_cnt", 32'd0);
    sel = 1'b0;

    rstn0 = 1'b1;
    push(0, 1, 0, 6'h00);
    drain();

    // R-type
    push(0, 1, 1, 6'h00); push(1, 1, 1, 6'h00); push(2, 1, 1, 6'h00);
    push(7, 1, 1, 6'h00); push(8, 1, 1, 6'h00);
    drain();
    chk_cnt("rtype_cnt", 32'd1);

    // lw with two stalled MEMRD cycles
    push(1, 1, 1, 6'h23); push(2, 1, 1, 6'h23); push(3, 1, 1, 6'h23);
    push(4, 0, 1, 6'h23); push(4, 0, 1, 6'h23); push(4, 1, 1, 6'h23);
    push(5, 1, 1, 6'h23);
    drain();
    chk_cnt("lw_cnt", 32'd2);

    // beq then j
    push(1, 1, 1, 6'h04); push(2, 1, 1, 6'h04); push(9, 1, 1, 6'h04);
    push(1, 1, 1, 6'h02); push(2, 1, 1, 6'h02); push(12, 1, 1, 6'h02);
    drain();
    chk_cnt("beq_j_cnt", 32'd4);

    // illegal opcode without trap: skip and refetch
    push(1, 1, 1, 6'h3F); push(2, 1, 1, 6'h3F); push(13, 1, 1, 6'h3F);
    drain();
    chk_cnt("illegal_skip_cnt", 32'd4);

    // sw with run dropped in DECODE, stalled once in MEMWR, then IDLE until run returns
    push(1, 1, 1, 6'h2B); push(2, 1, 0, 6'h2B); push(3, 1, 0, 6'h2B);
    push(6, 0, 0, 6'h2B); push(6, 1, 0, 6'h2B);
    push(0, 1, 0, 6'h2B); push(0, 1, 0, 6'h2B); push(0, 1, 1, 6'h2B);
    drain();
    chk_cnt("sw_cnt", 32'd5);

    // addi
    push(1, 1, 1, 6'h08); push(2, 1, 1, 6'h08); push(10, 1, 1, 6'h08);
    push(11, 1, 1, 6'h08);
    drain();
    chk_cnt("addi_cnt", 32'd6);

    // Reset asserted in the middle of a stalled MEMWR
    push(1, 1, 1, 6'h2B); push(2, 1, 1, 6'h2B); push(3, 1, 1, 6'h2B);
    drain();
    mem_ready = 1'b0;
    #1;
    chk_vec("memwr_before_reset", exp_vec(4'd6, 1'b0));
    rstn0 = 1'b0;
    #1;
    chk_vec("memwr_async_reset", '0);
    chk_cnt("memwr_reset_cnt", 32'd0);
    @(posedge clk); #1;
    chk_vec("reset_held_outputs", '0);

    // Trap variant: illegal opcode halts until reset
    sel = 1'b1;
    rstn1 = 1'b1;
    push(0, 1, 1, 6'h3F); push(1, 1, 1, 6'h3F); push(2, 1, 1, 6'h3F);
    push(13, 1, 1, 6'h3F); push(14, 1, 1, 6'h3F); push(14, 0, 0, 6'h3F);
    push(14, 1, 1, 6'h00); push(14, 0, 0, 6'h00);
    drain();
    chk_cnt("halt_cnt", 32'd0);
    rstn1 = 1'b0;
    #1;
    chk_vec("halt_reset_outputs", '0);
    run = 1'b0;
    @(posedge clk); #1;
    rstn1 = 1'b1;
    push(0, 1, 0, 6'h00); push(0, 1, 1, 6'h00); push(1, 1, 1, 6'h00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
